vga_timing_gen: RTL

- Generates the VGA raster timing for the 640x480@60 Hz display path from the 25.175 MHz pixel clock.
- Drives vga_x, vga_y and video_on into the sprite/overlay display stages.
- Drives hsync and vsync to the panel. These are delayed by a programmable number of cycles so they line up with the downstream pixel pipeline latency.
- Also provides frame_start and line_start strobes for animation and frame-counting logic.

---
 rtl/vga_timing_gen.sv | 122 ++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Raster timing generator for a 640x480@60 Hz display driven from the
//   25.175 MHz pixel clock. A horizontal/vertical counter pair walks the
//   full raster, including the blanking intervals. The visible-area flag
//   and the line/frame strobes are decoded directly from those counters.
//   hsync/vsync go through a short register chain so they line up with the
//   pixel pipeline further downstream.
//
// Ports
//   vga_clk      in   pixel clock, all logic on its rising edge
//   sys_rst      in   synchronous active-high reset
//   vga_x        out  horizontal count, 0..H_TOTAL-1
//   vga_y        out  vertical count, 0..V_TOTAL-1
//   video_on     out  current position lies in the visible area
//   hsync        out  horizontal sync, delayed by SYNC_DELAY cycles
//   vsync        out  vertical sync, delayed by SYNC_DELAY cycles
//   frame_start  out  one-cycle pulse at position (0,0)
//   line_start   out  one-cycle pulse at x=0 on every line
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter logic        SYNC_POL   = 1'b0,
  parameter int unsigned SYNC_DELAY = 3
) (
  input  logic       vga_clk,
  input  logic       sys_rst,
  output logic [9:0] vga_x,
  output logic [9:0] vga_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic       line_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       run;
  logic       hs_raw;
  logic       vs_raw;

  // The first edge after reset only sets run, so (0,0) is held for exactly
  // one cycle before the counters start advancing.
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
      run   <= 1'b0;
    end else if (!run) begin
      run <= 1'b1;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      if (v_cnt == V_LAST) begin
        v_cnt <= '0;
      end else begin
        v_cnt <= v_cnt + 10'd1;
      end
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  always_comb begin
    vga_x       = h_cnt;
    vga_y       = v_cnt;
    video_on    = run && (h_cnt < H_VIS) && (v_cnt < V_VIS);
    line_start  = run && (h_cnt == '0);
    frame_start = line_start && (v_cnt == '0);
    hs_raw      = (run && (h_cnt >= HS_START) && (h_cnt < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vs_raw      = (run && (v_cnt >= VS_START) && (v_cnt < VS_END)) ? SYNC_POL : ~SYNC_POL;
  end

  generate
    if (SYNC_DELAY == 0) begin : g_no_delay
      assign hsync = hs_raw;
      assign vsync = vs_raw;
    end else begin : g_delay
      logic hs_dly [SYNC_DELAY];
      logic vs_dly [SYNC_DELAY];

      // The whole chain is cleared to the idle level so no stale sync
      // pulse leaks out after a mid-frame reset.
      always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
          for (int unsigned i = 0; i < SYNC_DELAY; i++) begin
            hs_dly[i] <= ~SYNC_POL;
            vs_dly[i] <= ~SYNC_POL;
          end
        end else begin
          hs_dly[0] <= hs_raw;
          vs_dly[0] <= vs_raw;
          for (int unsigned i = 1; i < SYNC_DELAY; i++) begin
            hs_dly[i] <= hs_dly[i-1];
            vs_dly[i] <= vs_dly[i-1];
          end
        end
      end

      assign hsync = hs_dly[SYNC_DELAY-1];
      assign vsync = vs_dly[SYNC_DELAY-1];
    end
  endgenerate

endmodule
